cdc_req_ack_tx: RTL
===================

Name: cdc_req_ack_tx

Overview:
- TX-domain sender stage of the req/ack CDC path; sits directly upstream of the enable-based synchronizer.
- Accepts a word from a valid/ready source in the TX domain, then freezes it on o_data.
- Raises a level request that the RX side synchronizes as its enable, and runs a 4-phase handshake against an acknowledge returned from the RX domain.
- Guarantees that o_data is stable for the whole time the RX side may sample it.

Parameters:
- WIDTH, 4, data word width in bits.
- SYNC_STAGES, 2, flop count of the internal i_ack synchronizer (minimum 2).
- TIMEOUT, 1024, maximum TX cycles spent in REQ waiting for ack; 0 disables the timeout.

Ports:
- i_clk_tx  input  1  TX-domain clock; all logic is on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  source has a word on i_data.
- i_data  input  WIDTH  source data word.
- o_ready  output  1  block can accept a word this cycle.
- o_req  output  1  registered request level to the RX synchronizer.
- o_data  output  WIDTH  registered, held data word presented to the RX domain.
- i_ack  input  1  acknowledge level from the RX domain; asynchronous to i_clk_tx.
- o_busy  output  1  high whenever state is not IDLE.
- o_done  output  1  one-cycle pulse when a transfer completes normally.
- o_timeout  output  1  one-cycle pulse when the REQ wait expires.

Behaviour:
Reset values:
- All outputs, state, timeout counter and synchronizer flops are 0; state = IDLE.
- Reset may arrive mid-transfer: the block aborts immediately to IDLE with o_req = 0.

ack_s:
- i_ack passed through SYNC_STAGES flops on i_clk_tx.
- Only ack_s is used internally. Raw i_ack never reaches logic.

o_ready:
- o_ready = (state == IDLE) && !ack_s, combinational from registers only.
- If ack_s is high in IDLE (stale ack), acceptance is blocked until it drops.

States:
- IDLE:
  - Accept when i_valid && o_ready at a clock edge.
  - On accept: o_data <= i_data, o_req <= 1, counter <= 0, go to REQ.
  - o_req is high 1 cycle after the accept edge.
- REQ:
  - o_req held at 1; o_data held.
  - If ack_s == 1: o_req <= 0, go to WAIT_LOW.
  - Otherwise, if TIMEOUT != 0 and counter == TIMEOUT-1: o_timeout pulses 1 cycle, o_req <= 0, set internal flag tmo = 1, go to WAIT_LOW.
  - Otherwise counter increments.
  - If ack and timeout occur on the same edge, ack wins and there is no o_timeout pulse.
- WAIT_LOW:
  - o_req = 0; o_data still held.
  - If ack_s == 0: go to IDLE, clear tmo, and pulse o_done for 1 cycle only if tmo == 0.
- Counter width is clog2(TIMEOUT+1), minimum 1 bit. It is reset to 0 in IDLE.

Data and source rules:
- o_data changes only on an accept edge. It is never modified in REQ or WAIT_LOW.
- i_valid outside IDLE is ignored. The source holds i_valid and i_data until it sees o_ready.
- No combinational path from i_valid/i_data to any output.

Latency:
- Best-case accept-to-done = 1 + 2·SYNC_STAGES + RX response cycles.
- After o_done, o_ready is high on the next cycle (ack_s is already 0).

Test Plan:
- Reset, then i_valid=1, i_data=4'hA; i_ack driven high 3 cycles after o_req rises and low 3 cycles after o_req falls.
  - Required: o_req=1 one cycle after accept.
  - Required: o_data=4'hA held throughout.
  - Required: o_req falls SYNC_STAGES+1 cycles after the i_ack rise.
  - Required: single o_done pulse; o_ready returns.
- i_valid with 4'h3 held high continuously during a transfer of 4'h5.
  - Required: 4'h3 is not accepted until IDLE, and o_data stays 4'h5 until then.
  - Required: 4'h3 is then accepted.
- TIMEOUT=8, i_ack held 0.
  - Required: o_timeout pulses exactly 8 cycles after entering REQ, and o_req drops.
  - Required: no o_done; returns to IDLE after ack_s low (2 cycles).
- i_ack=1 at reset release with i_valid=1.
  - Required: o_ready=0 and no accept while ack_s is high.
  - Required: accept occurs the first cycle ack_s is 0.
- Assert i_rst_n=0 while in REQ with o_data=4'hF.
  - Required: o_req, o_data, o_busy go to 0 immediately (async).
  - Required: after release, state is IDLE with o_ready=1.
- TIMEOUT=4, i_ack rising so that ack_s rises on the same edge the counter reaches 3.
  - Required: o_req drops, with no o_timeout pulse.
  - Required: o_done pulses after ack low.

Source files
------------

// File: rtl/cdc_req_ack_tx.sv
// TX-side sender of the req/ack CDC path: captures one word, holds it on
// o_data and runs a 4-phase level handshake against the synchronized ack.
module cdc_req_ack_tx #(
    parameter int          WIDTH       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic             i_clk_tx,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_req,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ack,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   tmo, tmo_nx;
    logic                   req_nx, done_nx, to_nx;
    logic [WIDTH-1:0]       data_nx;
    logic [SYNC_STAGES-1:0] ack_q;
    logic                   ack_s;

    // i_ack is asynchronous; only the last synchronizer stage is consumed
    always_ff @(posedge i_clk_tx or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q <= '0;
        end else begin
            ack_q <= {ack_q[SYNC_STAGES-2:0], i_ack};
        end
    end

    assign ack_s   = ack_q[SYNC_STAGES-1];
    assign o_ready = (state == IDLE) && !ack_s;
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tmo_nx   = tmo;
        req_nx   = o_req;
        data_nx  = o_data;
        done_nx  = 1'b0;
        to_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (i_valid && o_ready) begin
                    data_nx  = i_data;
                    req_nx   = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                // ack is checked first so it wins a tie with the timeout
                if (ack_s) begin
                    req_nx   = 1'b0;
                    state_nx = WAIT_LOW;
                end else if (TMO_EN && cnt == CNT_LAST) begin
                    to_nx    = 1'b1;
                    req_nx   = 1'b0;
                    tmo_nx   = 1'b1;
                    state_nx = WAIT_LOW;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    state_nx = IDLE;
                    tmo_nx   = 1'b0;
                    done_nx  = !tmo;
                end
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_tx or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tmo       <= 1'b0;
            o_req     <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tmo       <= tmo_nx;
            o_req     <= req_nx;
            o_data    <= data_nx;
            o_done    <= done_nx;
            o_timeout <= to_nx;
        end
    end

endmodule
